// File: rtl/cell_cursor_editor_if.sv
// Button, run and placement-handshake signals between the editor and its neighbours.
// The slave modport is the editor's view and the master modport is the driver's view.
interface cell_cursor_editor_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_place;
  logic       run;
  logic [7:0] xcoordinate;
  logic [7:0] ycoordinate;
  logic       coordinatesready;
  logic       busy;

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, run,
    output xcoordinate, ycoordinate, coordinatesready, busy
  );

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, run,
    input  xcoordinate, ycoordinate, coordinatesready, busy
  );
endinterface

// File: rtl/cell_cursor_editor.sv
// Debounces five push-buttons into a wrapping grid cursor and issues toggle-style placements.
// Each button press reaches the outputs 3 + DEBOUNCE_CYCLES cycles after its raw edge.
// After a placement, all requests are dropped for HOLD_CYCLES cycles.
module cell_cursor_editor #(
  parameter int COLS            = 80,
  parameter int ROWS            = 48,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 4
) (
  input logic                  clk,
  input logic                  reset,
  cell_cursor_editor_if.slave  bus
);

  localparam int NB = 5;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [7:0]    X_MAX     = 8'(COLS - 1);
  localparam logic [7:0]    Y_MAX     = 8'(ROWS - 1);

  // Button index map: 0 up, 1 down, 2 left, 3 right, 4 place
  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync2_q, deb_q, press_q;
  logic [CW-1:0] cnt_q [NB];

  assign raw = {bus.btn_place, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < NB; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == DEB_LAST) begin
            deb_q[i]   <= ~deb_q[i];
            cnt_q[i]   <= '0;
            press_q[i] <= ~deb_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    x_q, x_d, y_q, y_d;
  logic          cr_q, cr_d, busy_q, busy_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          place_ev;

  assign place_ev = press_q[4] && !bus.run;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cr_q    <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cr_q    <= cr_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (place_ev) state_d = HOLD;
      HOLD:    if (hold_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    cr_d   = cr_q;
    busy_d = busy_q;
    hold_d = hold_q;
    case (state_q)
      IDLE: begin
        // A placement wins over moves in the same cycle so the sent coordinates are pre-move
        if (place_ev) begin
          cr_d   = ~cr_q;
          hold_d = HOLD_LAST;
          busy_d = 1'b1;
        end else begin
          if (press_q[2] && !press_q[3])      x_d = (x_q == 8'd0)  ? X_MAX : x_q - 8'd1;
          else if (press_q[3] && !press_q[2]) x_d = (x_q == X_MAX) ? 8'd0  : x_q + 8'd1;
          if (press_q[0] && !press_q[1])      y_d = (y_q == 8'd0)  ? Y_MAX : y_q - 8'd1;
          else if (press_q[1] && !press_q[0]) y_d = (y_q == Y_MAX) ? 8'd0  : y_q + 8'd1;
        end
      end
      HOLD: begin
        if (hold_q == '0) busy_d = 1'b0;
        else              hold_d = hold_q - 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.xcoordinate      = x_q;
  assign bus.ycoordinate      = y_q;
  assign bus.coordinatesready = cr_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_cell_cursor_editor.sv
// Directed bench for cell_cursor_editor with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=3.
// A button press shows at the outputs 7 clock edges after its raw edge.
module tb_cell_cursor_editor;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  cell_cursor_editor_if bus ();

  cell_cursor_editor #(
    .COLS(80), .ROWS(48), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mask bits: 0 up, 1 down, 2 left, 3 right, 4 place
  task automatic set_btns(input logic [4:0] m);
    bus.btn_up    = m[0];
    bus.btn_down  = m[1];
    bus.btn_left  = m[2];
    bus.btn_right = m[3];
    bus.btn_place = m[4];
  endtask

  task automatic press(input logic [4:0] m);
    set_btns(m);
    repeat (7) tick();
    set_btns(5'b0);
    repeat (7) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_btns(5'b0);
    bus.run = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (bus.xcoordinate !== 8'd0 || bus.ycoordinate !== 8'd0 ||
        bus.coordinatesready !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got x=%0d y=%0d cr=%b busy=%b want 0 0 0 0",
               bus.xcoordinate, bus.ycoordinate, bus.coordinatesready, bus.busy);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    set_btns(5'b01000);
    repeat (6) tick();
    n_vec++;
    if (bus.xcoordinate !== 8'd0) begin
      n_err++;
      $display("FAIL latency_early got x=%0d want 0", bus.xcoordinate);
    end
    tick();
    n_vec++;
    if (bus.xcoordinate !== 8'd1) begin
      n_err++;
      $display("FAIL latency_step got x=%0d want 1", bus.xcoordinate);
    end
    repeat (3) tick();
    n_vec++;
    if (bus.xcoordinate !== 8'd1 || bus.ycoordinate !== 8'd0 || bus.coordinatesready !== 1'b0) begin
      n_err++;
      $display("FAIL single_press got x=%0d y=%0d cr=%b want 1 0 0",
               bus.xcoordinate, bus.ycoordinate, bus.coordinatesready);
    end
    set_btns(5'b0);
    repeat (7) tick();
    press(5'b00100);
  endtask

  task automatic test_wrap();
    press(5'b00100);
    n_vec++;
    if (bus.xcoordinate !== 8'd79 || bus.ycoordinate !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_left got x=%0d y=%0d want 79 0", bus.xcoordinate, bus.ycoordinate);
    end
    press(5'b00001);
    n_vec++;
    if (bus.xcoordinate !== 8'd79 || bus.ycoordinate !== 8'd47) begin
      n_err++;
      $display("FAIL wrap_up got x=%0d y=%0d want 79 47", bus.xcoordinate, bus.ycoordinate);
    end
    press(5'b01010);
    n_vec++;
    if (bus.xcoordinate !== 8'd0 || bus.ycoordinate !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_right_down got x=%0d y=%0d want 0 0", bus.xcoordinate, bus.ycoordinate);
    end
  endtask

  task automatic test_place_hold();
    for (int i = 0; i < 5; i++) press(5'b01010);
    for (int i = 0; i < 2; i++) press(5'b00010);
    n_vec++;
    if (bus.xcoordinate !== 8'd5 || bus.ycoordinate !== 8'd7) begin
      n_err++;
      $display("FAIL move_to_5_7 got x=%0d y=%0d want 5 7", bus.xcoordinate, bus.ycoordinate);
    end
    set_btns(5'b10000);
    tick();
    set_btns(5'b11000);
    repeat (5) tick();
    n_vec++;
    if (bus.coordinatesready !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL place_early got cr=%b busy=%b want 0 0", bus.coordinatesready, bus.busy);
    end
    tick();
    n_vec++;
    if (bus.coordinatesready !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL place_toggle got cr=%b busy=%b want 1 1", bus.coordinatesready, bus.busy);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_hold cycle %0d got busy=%b want 1", i + 2, bus.busy);
      end
    end
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.xcoordinate !== 8'd5 || bus.coordinatesready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_end got busy=%b x=%0d cr=%b want 0 5 1",
               bus.busy, bus.xcoordinate, bus.coordinatesready);
    end
    set_btns(5'b0);
    repeat (8) tick();
    n_vec++;
    if (bus.xcoordinate !== 8'd5) begin
      n_err++;
      $display("FAIL move_dropped got x=%0d want 5", bus.xcoordinate);
    end
  endtask

  task automatic test_glitch_and_run();
    logic seen_busy;
    seen_busy = 1'b0;
    for (int r = 0; r < 6; r++) begin
      set_btns(5'b10000);
      for (int k = 0; k < 3; k++) begin tick(); seen_busy |= bus.busy; end
      set_btns(5'b0);
      tick();
      seen_busy |= bus.busy;
    end
    repeat (7) begin tick(); seen_busy |= bus.busy; end
    n_vec++;
    if (bus.coordinatesready !== 1'b1 || seen_busy !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_place got cr=%b busy_seen=%b want 1 0", bus.coordinatesready, seen_busy);
    end
    bus.run = 1'b1;
    set_btns(5'b10000);
    repeat (7) begin tick(); seen_busy |= bus.busy; end
    set_btns(5'b0);
    repeat (7) begin tick(); seen_busy |= bus.busy; end
    bus.run = 1'b0;
    n_vec++;
    if (bus.coordinatesready !== 1'b1 || seen_busy !== 1'b0) begin
      n_err++;
      $display("FAIL run_inhibit got cr=%b busy_seen=%b want 1 0", bus.coordinatesready, seen_busy);
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 4; i++) press(5'b01001);
    press(5'b01000);
    n_vec++;
    if (bus.xcoordinate !== 8'd10 || bus.ycoordinate !== 8'd3) begin
      n_err++;
      $display("FAIL move_to_10_3 got x=%0d y=%0d want 10 3", bus.xcoordinate, bus.ycoordinate);
    end
    set_btns(5'b11000);
    repeat (7) tick();
    n_vec++;
    if (bus.coordinatesready !== 1'b0 || bus.busy !== 1'b1 ||
        bus.xcoordinate !== 8'd10 || bus.ycoordinate !== 8'd3) begin
      n_err++;
      $display("FAIL place_plus_right got cr=%b busy=%b x=%0d y=%0d want 0 1 10 3",
               bus.coordinatesready, bus.busy, bus.xcoordinate, bus.ycoordinate);
    end
    set_btns(5'b0);
    repeat (7) tick();
    n_vec++;
    if (bus.xcoordinate !== 8'd10 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL place_plus_right_after got x=%0d busy=%b want 10 0", bus.xcoordinate, bus.busy);
    end
    press(5'b01100);
    n_vec++;
    if (bus.xcoordinate !== 8'd10) begin
      n_err++;
      $display("FAIL left_plus_right got x=%0d want 10", bus.xcoordinate);
    end
  endtask

  task automatic test_reset_mid_hold();
    set_btns(5'b10000);
    repeat (7) tick();
    n_vec++;
    if (bus.coordinatesready !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_toggle got cr=%b busy=%b want 1 1", bus.coordinatesready, bus.busy);
    end
    tick();
    reset = 1'b0;
    set_btns(5'b0);
    tick();
    n_vec++;
    if (bus.xcoordinate !== 8'd0 || bus.ycoordinate !== 8'd0 ||
        bus.coordinatesready !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_hold got x=%0d y=%0d cr=%b busy=%b want 0 0 0 0",
               bus.xcoordinate, bus.ycoordinate, bus.coordinatesready, bus.busy);
    end
    reset = 1'b1;
    repeat (3) tick();
    set_btns(5'b10000);
    repeat (7) tick();
    n_vec++;
    if (bus.coordinatesready !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL fresh_place got cr=%b busy=%b want 1 1", bus.coordinatesready, bus.busy);
    end
    set_btns(5'b0);
    repeat (7) tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_place_hold();
    test_glitch_and_run();
    test_same_cycle();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cell_cursor_editor.md
Name: cell_cursor_editor

Overview:
- Upstream editing stage for the life engine. Turns five raw push-buttons into a wrapping cursor on the 80x48 cell grid.
- Emits the toggle-style placement handshake (`xcoordinate`, `ycoordinate`, `coordinatesready`) that the engine samples on its slow clock.
- Guarantees each toggle and its coordinates stay stable long enough for the slow-clock consumer to see them.

Parameters:
- `COLS`, 80, grid width in cells; x range 0..COLS-1.
- `ROWS`, 48, grid height in cells; y range 0..ROWS-1.
- `DEBOUNCE_CYCLES`, 250000, consecutive clk cycles a synchronised button level must differ from the debounced level before the debounced level flips.
- `HOLD_CYCLES`, 4, clk cycles after a placement toggle during which coordinates are frozen and new requests are dropped. Minimum 2.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `btn_up`  in  1  raw async button: y-1
- `btn_down`  in  1  raw async button: y+1
- `btn_left`  in  1  raw async button: x-1
- `btn_right`  in  1  raw async button: x+1
- `btn_place`  in  1  raw async button: request placement at cursor
- `run`  in  1  level; high while the engine is running (`start`), which inhibits placement
- `xcoordinate`  out  8  cursor column
- `ycoordinate`  out  8  cursor row
- `coordinatesready`  out  1  toggles once per accepted placement
- `busy`  out  1  high during HOLD

Behaviour:
- Reset (`clk` edge with `reset`==0): `xcoordinate`=0, `ycoordinate`=0, `coordinatesready`=0, `busy`=0, FSM=IDLE, all synchronisers, debounced levels and counters = 0. Reset mid-HOLD aborts the hold. The downstream engine is reset in the same domain event, so forcing the toggle to 0 is not a placement.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce counter, width $clog2(DEBOUNCE_CYCLES+1). It increments while synced != debounced and clears otherwise. On reaching DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - Press event = debounced 0->1, a 1-cycle pulse. Releases generate no events.
- Latency:
  - Raw edge held stable -> press pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Press pulse -> output change: next clk edge (1 cycle).
- Movement, IDLE only, one step per event, modulo wrap:
  - left: x==0 -> COLS-1, else x-1.
  - right: x==COLS-1 -> 0, else x+1.
  - up / down: same rule on y with ROWS.
  - left+right pulses in the same cycle: x unchanged. up+down same cycle: y unchanged.
  - x and y may both move in one cycle.
- FSM:
  - IDLE:
    - place pulse and `run`==0 -> `coordinatesready` <= ~`coordinatesready`, hold counter <= HOLD_CYCLES-1, `busy` <= 1, go to HOLD.
    - Any move pulse in that same cycle is dropped, so the coordinates sent are the pre-move values.
    - place pulse with `run`==1 -> ignored; stay IDLE; moves still honoured.
  - HOLD:
    - x, y and `coordinatesready` frozen; all move and place pulses dropped, not queued.
    - Counter decrements each cycle; at 0 -> IDLE, `busy` <= 0.
    - `busy` is high for exactly HOLD_CYCLES cycles per placement.
  - `run` rising during HOLD does not affect the hold or revert the toggle.
- Invariants:
  - x < COLS and y < ROWS always.
  - Upper output bits beyond the needed width are 0.
  - `coordinatesready` changes only on IDLE->HOLD.

Test Plan (sim with DEBOUNCE_CYCLES=4, HOLD_CYCLES=3):
- Reset, then hold `btn_right` 1 for 10 cycles -> exactly one press pulse 6 cycles after the raw edge; `xcoordinate` 0->1; `ycoordinate` 0; `coordinatesready` 0.
- From (0,0) press left once and up once -> (79,47). Then press right and down -> (0,0) (both wraps).
- Cursor (5,7), `run`=0, press place -> `coordinatesready` 0->1 next cycle; `busy` high 3 cycles. A right press landing inside HOLD is dropped; x stays 5.
- Glitchy `btn_place` (1 for 3 cycles, 0 for 1, repeated) -> no press event, no toggle. A clean press with `run`=1 -> no toggle, `busy` stays 0.
- Place and right pulses in the same IDLE cycle at (10,3) -> toggle with coordinates (10,3), x unchanged after HOLD. Left+right in the same cycle -> x unchanged.
- Assert `reset`=0 on the second HOLD cycle -> next edge: (0,0), `coordinatesready`=0, `busy`=0, FSM IDLE; a fresh place press toggles 0->1.
